sram_word_bridge: RTL and testbench

- Bridges the DLX processor's 32-bit data/instruction memory port to the 16-bit asynchronous-style SRAM pin interface (`sram_*`).
- Sits between the core-side memory request port and the external 16-bit single-port RAM, where the SRAM reads synchronously.
- Each 32-bit access becomes two sequential 16-bit SRAM accesses, with byte-enable mapping and a single-cycle `ack` on completion.

---
 rtl/udlx_sram_pkg.sv | 21 ++
 rtl/sram_word_bridge.sv | 114 +++++++++++
 tb/tb_sram_word_bridge.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/udlx_sram_pkg.sv
// Shared types and constants for the 32-bit core to 16-bit SRAM word bridge.
package udlx_sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_LO,
        ST_ISSUE_HI,
        ST_CAPTURE_HI,
        ST_RESP
    } sram_bridge_state_t;

    localparam logic HALF_LO     = 1'b0;
    localparam logic HALF_HI     = 1'b1;
    localparam int   WORD_HALVES = 2;

    // Byte-enable pair {ub, lb} belonging to one 16-bit half of the word.
    function automatic logic [1:0] half_be(input logic [3:0] be, input logic half);
        return half ? be[3:2] : be[1:0];
    endfunction

endpackage

// File: rtl/sram_word_bridge.sv
// Splits each 32-bit core access into two 16-bit synchronous SRAM accesses
// (low half at the even address first) and returns a one-cycle ack.
module sram_word_bridge
    import udlx_sram_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH      = 9,
    parameter int SRAM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic                       we,
    input  logic [ADDR_WIDTH-1:0]      addr,
    input  logic [3:0]                 be,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       ack,
    output logic                       busy,
    output logic                       sram_ce_n,
    output logic                       sram_we_n,
    output logic                       sram_oe_n,
    output logic                       sram_ub_n,
    output logic                       sram_lb_n,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data
);

    sram_bridge_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]      addr_q;
    logic                       we_q;
    logic [3:0]                 be_q;
    logic [DATA_WIDTH-1:0]      wr_q;
    logic [SRAM_DATA_WIDTH-1:0] lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Request latch and read assembly; rd_data only moves on entry to RESP of a read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wr_q    <= '0;
            lo_q    <= '0;
            rd_data <= '0;
        end else begin
            if (state == ST_IDLE && req) begin
                addr_q <= addr;
                we_q   <= we;
                be_q   <= be;
                wr_q   <= wr_data;
            end
            if (state == ST_ISSUE_HI && !we_q) lo_q <= sram_rd_data;
            if (state == ST_CAPTURE_HI)        rd_data <= {sram_rd_data, lo_q};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:       if (req) state_nxt = ST_ISSUE_LO;
            ST_ISSUE_LO:   state_nxt = ST_ISSUE_HI;
            ST_ISSUE_HI:   state_nxt = we_q ? ST_RESP : ST_CAPTURE_HI;
            ST_CAPTURE_HI: state_nxt = ST_RESP;
            ST_RESP:       state_nxt = ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    assign ack  = (state == ST_RESP);
    assign busy = (state != ST_IDLE);

    // Pin decode depends only on registered state and latched request fields.
    logic       issue;
    logic       half;
    logic [1:0] hbe;

    always_comb begin
        issue        = (state == ST_ISSUE_LO) || (state == ST_ISSUE_HI);
        half         = (state == ST_ISSUE_HI) ? HALF_HI : HALF_LO;
        hbe          = half_be(be_q, half);
        sram_ce_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_ub_n    = 1'b1;
        sram_lb_n    = 1'b1;
        sram_addr    = '0;
        sram_wr_data = '0;
        if (issue) begin
            sram_addr    = {addr_q, half};
            sram_wr_data = half ? wr_q[DATA_WIDTH-1:SRAM_DATA_WIDTH] : wr_q[SRAM_DATA_WIDTH-1:0];
            if (we_q) begin
                // A half with no enabled bytes is left deselected but still costs its cycle.
                sram_ce_n = ~|hbe;
                sram_we_n = 1'b0;
                sram_lb_n = ~hbe[0];
                sram_ub_n = ~hbe[1];
            end else begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_lb_n = 1'b0;
                sram_ub_n = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_word_bridge.sv
// Random and directed checks of sram_word_bridge against a word-level memory model.
module tb_sram_word_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [8:0]  addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        ack, busy;
    logic        sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
    logic [9:0]  sram_addr;
    logic [15:0] sram_wr_data;
    logic [15:0] sram_rd_data;

    sram_word_bridge dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be),
        .wr_data(wr_data), .rd_data(rd_data), .ack(ack), .busy(busy),
        .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .sram_addr(sram_addr),
        .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data)
    );

    always #5 clk = ~clk;

    // Synchronous 16-bit SRAM with byte lanes and registered read output.
    logic [15:0] mem [1024];
    logic [15:0] mem_rd_q = '0;
    assign sram_rd_data = mem_rd_q;

    always @(posedge clk) begin
        if (!sram_ce_n) begin
            if (!sram_we_n) begin
                if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_wr_data[7:0];
                if (!sram_ub_n) mem[sram_addr][15:8] <= sram_wr_data[15:8];
            end else if (!sram_oe_n) begin
                mem_rd_q <= mem[sram_addr];
            end
        end
    end

    // Word-level reference: 32-bit words with byte-granular writes.
    logic [31:0] ref_mem [512];
    int          n_chk = 0;
    int          n_err = 0;
    logic        ce_log [16];
    logic [9:0]  addr_log [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int a, input logic [31:0] v);
        ref_mem[a]   = v;
        mem[2*a]     = v[15:0];
        mem[2*a + 1] = v[31:16];
    endtask

    task automatic ref_write(input int a, input logic [3:0] b, input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (b[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
    endtask

    // One access with req held until ack; returns cycles from req to ack (-1 on timeout).
    task automatic access(input logic w, input logic [8:0] a, input logic [3:0] b,
                          input logic [31:0] d, output int lat, output logic [31:0] rdat);
        lat  = -1;
        rdat = '0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; be = b; wr_data = d;
        for (int n = 1; n < 16; n++) begin
            @(posedge clk); #1;
            ce_log[n]   = sram_ce_n;
            addr_log[n] = sram_addr;
            if (ack) begin
                lat  = n;
                rdat = rd_data;
                break;
            end
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic do_txn(input string tag, input logic w, input logic [8:0] a,
                          input logic [3:0] b, input logic [31:0] d);
        int          lat;
        logic [31:0] rdat;
        access(w, a, b, d, lat, rdat);
        chk({tag, "_lat"}, lat, w ? 3 : 4);
        if (w) ref_write(int'(a), b, d);
        else   chk({tag, "_rd"}, rdat, ref_mem[a]);
    endtask

    initial begin
        int          lat, t1, t2, nack;
        logic [31:0] rdat, d1, d2;

        for (int i = 0; i < 512; i++) set_word(i, $urandom);

        // Reset state
        #12;
        chk("rst_ack", {31'b0, ack}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_ctrl", {27'b0, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 32'h1F);
        chk("rst_saddr", {22'b0, sram_addr}, 0);
        chk("rst_swdata", {16'b0, sram_wr_data}, 0);
        @(negedge clk); rst = 1'b0;

        // Directed read with address sequence
        set_word(8, 32'hDEADBEEF);
        access(1'b0, 9'h008, 4'hF, 32'h0, lat, rdat);
        chk("rd_lat", lat, 4);
        chk("rd_data", rdat, 32'hDEADBEEF);
        chk("rd_addr_lo", {22'b0, addr_log[1]}, 32'h010);
        chk("rd_addr_hi", {22'b0, addr_log[2]}, 32'h011);
        chk("rd_ce_lo", {31'b0, ce_log[1]}, 0);

        // Full write then read back through the bench's SRAM
        do_txn("wr_full", 1'b1, 9'h003, 4'hF, 32'h12345678);
        chk("wr_full_m6", {16'b0, mem[6]}, 32'h5678);
        chk("wr_full_m7", {16'b0, mem[7]}, 32'h1234);

        // Partial write: only byte 2 enabled
        set_word(3, 32'hFFFFFFFF);
        access(1'b1, 9'h003, 4'b0100, 32'hAABBCCDD, lat, rdat);
        ref_write(3, 4'b0100, 32'hAABBCCDD);
        chk("wr_part_lat", lat, 3);
        chk("wr_part_ce_lo", {31'b0, ce_log[1]}, 1);
        chk("wr_part_ce_hi", {31'b0, ce_log[2]}, 0);
        chk("wr_part_m6", {16'b0, mem[6]}, 32'hFFFF);
        chk("wr_part_m7", {16'b0, mem[7]}, 32'hFFBB);
        do_txn("wr_part_rb", 1'b0, 9'h003, 4'hF, 32'h0);

        // be=0 write: no SRAM select at all
        access(1'b1, 9'h004, 4'h0, 32'h01020304, lat, rdat);
        chk("wr_be0_lat", lat, 3);
        chk("wr_be0_ce", {30'b0, ce_log[1], ce_log[2]}, 32'h3);
        do_txn("wr_be0_rb", 1'b0, 9'h004, 4'hF, 32'h0);

        // Back-to-back reads with req held
        d1 = 0; d2 = 0; t1 = -1; t2 = -1; nack = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 9'h000; be = 4'hF;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk); #1;
            if (ack) begin
                nack++;
                if (nack == 1) begin t1 = n; d1 = rd_data; end
                else           begin t2 = n; d2 = rd_data; end
                @(negedge clk);
                if (nack == 1) addr = 9'h001;
                else           req = 1'b0;
            end
        end
        req = 1'b0;
        chk("b2b_nack", nack, 2);
        chk("b2b_t1", t1, 4);
        chk("b2b_gap", t2 - t1, 5);
        chk("b2b_d0", d1, ref_mem[0]);
        chk("b2b_d1", d2, ref_mem[1]);

        // Stray req pulse mid-transaction is ignored
        nack = 0; t1 = -1; d1 = 0;
        @(negedge clk);
        req = 1'b1; addr = 9'h005; we = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (ack) begin nack++; t1 = n; d1 = rd_data; end
            @(negedge clk);
            req  = (n == 2);
            addr = (n == 2) ? 9'h00A : 9'h005;
        end
        req = 1'b0;
        chk("stray_nack", nack, 1);
        chk("stray_t", t1, 4);
        chk("stray_d", d1, ref_mem[5]);

        // Reset during ISSUE_HI of a write
        set_word(32, 32'h11112222);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 9'h020; be = 4'hF; wr_data = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_ctrl", {27'b0, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 32'h1F);
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_ack", {31'b0, ack}, 0);
        chk("arst_rd_data", rd_data, 0);
        @(negedge clk); req = 1'b0;
        @(negedge clk); rst = 1'b0;
        ref_mem[32][15:0] = 16'hF00D;
        do_txn("arst_rb", 1'b0, 9'h020, 4'hF, 32'h0);

        // Random mix on a small address window to force overlap
        for (int k = 0; k < 40; k++)
            do_txn("rnd", 1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)),
                   4'($urandom), $urandom);
        for (int a = 0; a < 16; a++)
            do_txn("rnd_sweep", 1'b0, 9'(a), 4'hF, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
